// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Shared seven-segment codes, digit enables and decoder states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  typedef logic [1:0] dec_state_t;

  localparam dec_state_t ST_WAIT     = 2'd0;
  localparam dec_state_t ST_HAVE_ONE = 2'd1;
  localparam dec_state_t ST_PUBLISH  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/seg_display_decoder_seg7_to_bcd.sv
// ============================================================================
// Module      : seg7_to_bcd
// Description : Combinational active-low seven-segment pattern to BCD digit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       is_blank,
  output logic       is_valid
);

  always_comb begin
    digit    = 4'd0;
    is_blank = 1'b0;
    is_valid = 1'b1;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        is_blank = 1'b1;
        is_valid = 1'b0;
      end
      default:   is_valid = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_decoder.sv
// ============================================================================
// Module      : seg_display_decoder
// Description : Samples a scanned two-digit seven-segment bus and rebuilds the
//               displayed 0-15 value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [1:0] an,
  output logic [3:0] value,
  output logic       value_valid,
  output logic       value_update,
  output logic       err
);

  localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

  logic [6:0] r_seg_q, r_seg_p;
  logic [1:0] r_an_q, r_an_p;
  logic [3:0] r_stab_cnt;
  logic       r_captured;
  dec_state_t r_state;
  logic [3:0] r_ones, r_tens;
  logic       r_held_tens;
  logic [3:0] r_value;
  logic       r_value_valid, r_value_update, r_err;

  logic [3:0] w_digit;
  logic       w_is_blank, w_is_valid;
  logic       w_an_legal, w_same;
  logic [3:0] w_cnt_next;
  logic       w_capture, w_cap_tens, w_legal;
  logic [4:0] w_sum;

  seg7_to_bcd u_seg7_to_bcd (
    .seg      (r_seg_q),
    .digit    (w_digit),
    .is_blank (w_is_blank),
    .is_valid (w_is_valid)
  );

  assign w_an_legal = (r_an_q == AN_ONES) || (r_an_q == AN_TENS);
  assign w_same     = (r_seg_q == r_seg_p) && (r_an_q == r_an_p);

  always_comb begin
    w_cnt_next = 4'd0;
    if (w_same && w_an_legal)
      w_cnt_next = (r_stab_cnt == c_stable) ? r_stab_cnt : r_stab_cnt + 4'd1;
  end

  // Capture on the edge where the counter first reaches the threshold
  assign w_capture  = (w_cnt_next == c_stable) && (r_stab_cnt != c_stable) && !r_captured;
  assign w_cap_tens = (r_an_q == AN_TENS);
  // Tens position only ever shows 0, 1 or blank (blank reads as 0)
  assign w_legal    = w_cap_tens ? (w_is_blank || (w_is_valid && (w_digit <= 4'd1)))
                                 : w_is_valid;
  assign w_sum      = 5'(r_tens) * 5'd10 + 5'(r_ones);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q    <= SEG_BLANK;
      r_seg_p    <= SEG_BLANK;
      r_an_q     <= 2'b11;
      r_an_p     <= 2'b11;
      r_stab_cnt <= 4'd0;
      r_captured <= 1'b0;
    end else begin
      r_seg_q    <= seg;
      r_an_q     <= an;
      r_seg_p    <= r_seg_q;
      r_an_p     <= r_an_q;
      r_stab_cnt <= w_cnt_next;
      if (r_an_q != r_an_p)
        r_captured <= 1'b0;
      else if (w_capture)
        r_captured <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_WAIT;
      r_ones         <= 4'd0;
      r_tens         <= 4'd0;
      r_held_tens    <= 1'b0;
      r_value        <= 4'd0;
      r_value_valid  <= 1'b0;
      r_value_update <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_value_update <= 1'b0;
      r_err          <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (w_capture) begin
            if (w_legal) begin
              if (w_cap_tens) r_tens <= w_digit;
              else            r_ones <= w_digit;
              r_held_tens <= w_cap_tens;
              r_state     <= ST_HAVE_ONE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_HAVE_ONE: begin
          if (w_capture) begin
            if (!w_legal) begin
              r_err   <= 1'b1;
              r_ones  <= 4'd0;
              r_tens  <= 4'd0;
              r_state <= ST_WAIT;
            end else begin
              if (w_cap_tens) r_tens <= w_digit;
              else            r_ones <= w_digit;
              if (w_cap_tens != r_held_tens)
                r_state <= ST_PUBLISH;
            end
          end
        end
        ST_PUBLISH: begin
          if (w_sum <= 5'd15) begin
            r_value        <= w_sum[3:0];
            r_value_update <= 1'b1;
            r_value_valid  <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
          r_ones  <= 4'd0;
          r_tens  <= 4'd0;
          r_state <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  assign value        = r_value;
  assign value_valid  = r_value_valid;
  assign value_update = r_value_update;
  assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_decoder.sv
// ============================================================================
// Module      : tb_seg_display_decoder
// Description : Directed self-checking bench for seg_display_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_decoder;

  localparam logic [6:0] c_s0    = 7'b1000000;
  localparam logic [6:0] c_s1    = 7'b1111001;
  localparam logic [6:0] c_s2    = 7'b0100100;
  localparam logic [6:0] c_s3    = 7'b0110000;
  localparam logic [6:0] c_s4    = 7'b0011001;
  localparam logic [6:0] c_s5    = 7'b0010010;
  localparam logic [6:0] c_s6    = 7'b0000010;
  localparam logic [6:0] c_s9    = 7'b0010000;
  localparam logic [6:0] c_blank = 7'b1111111;
  localparam logic [6:0] c_bad   = 7'b0000001;
  localparam logic [1:0] c_ones  = 2'b10;
  localparam logic [1:0] c_tens  = 2'b01;
  localparam logic [1:0] c_idle  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = c_blank;
  logic [1:0] an  = c_idle;
  logic [3:0] value;
  logic       value_valid, value_update, err;

  int n_checks = 0;
  int n_errors = 0;
  int n_upd = 0, n_err = 0, n_both = 0;
  int upd0, err0;

  seg_display_decoder #(.STABLE_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg          (seg),
    .an           (an),
    .value        (value),
    .value_valid  (value_valid),
    .value_update (value_update),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (value_update) n_upd++;
    if (err) n_err++;
    if (value_update && err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [1:0] a, input int n);
    seg = s;
    an  = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    upd0 = n_upd;
    err0 = n_err;
  endtask

  task automatic pair(input logic [6:0] t, input logic [6:0] o);
    drive(t, c_tens, 4);
    drive(o, c_ones, 4);
    drive(c_blank, c_idle, 4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_value", value, 0);
    check("rst_valid", value_valid, 0);
    check("rst_update", value_update, 0);
    check("rst_err", err, 0);

    snap();
    drive(c_blank, c_idle, 20);
    check("idle_valid", value_valid, 0);
    check("idle_upd", n_upd - upd0, 0);
    check("idle_err", n_err - err0, 0);

    // Tens '1' / ones '2' with exact publish timing
    snap();
    drive(c_s1, c_tens, 4);
    drive(c_s2, c_ones, 4);
    check("upd_early", value_update, 0);
    drive(c_blank, c_idle, 1);
    check("upd_timing", value_update, 1);
    check("val_12", value, 12);
    drive(c_blank, c_idle, 3);
    check("upd_after", value_update, 0);
    pair(c_s1, c_s2);
    check("val_12b", value, 12);
    check("valid_12", value_valid, 1);
    check("upd_cnt_12", n_upd - upd0, 2);
    check("err_cnt_12", n_err - err0, 0);

    snap();
    pair(c_blank, c_s5);
    check("val_blank5", value, 5);
    pair(c_s0, c_s5);
    check("val_05", value, 5);
    check("upd_cnt_5", n_upd - upd0, 2);

    // Undecodable ones pattern
    snap();
    drive(c_bad, c_ones, 4);
    drive(c_blank, c_idle, 4);
    check("bad_err", n_err - err0, 1);
    check("bad_upd", n_upd - upd0, 0);
    check("bad_val", value, 5);
    pair(c_s1, c_s3);
    check("val_13", value, 13);
    check("upd_13", n_upd - upd0, 1);

    // Out-of-range pair 16
    snap();
    pair(c_s1, c_s6);
    check("ovr_err", n_err - err0, 1);
    check("ovr_upd", n_upd - upd0, 0);
    check("ovr_val", value, 13);

    // Short ones dwell must not capture; tens then overwritten
    snap();
    drive(c_s0, c_tens, 4);
    drive(c_s9, c_ones, 2);
    drive(c_blank, c_idle, 4);
    check("short_upd", n_upd - upd0, 0);
    check("short_err", n_err - err0, 0);
    pair(c_s1, c_s4);
    check("val_14", value, 14);
    check("upd_14", n_upd - upd0, 1);

    // Reset after tens capture
    drive(c_s1, c_tens, 4);
    rst = 1'b1;
    drive(c_blank, c_idle, 2);
    rst = 1'b0;
    check("mrst_value", value, 0);
    check("mrst_valid", value_valid, 0);
    check("mrst_update", value_update, 0);
    check("mrst_err", err, 0);
    snap();
    drive(c_s3, c_ones, 4);
    drive(c_blank, c_idle, 5);
    check("ones_only_upd", n_upd - upd0, 0);
    check("ones_only_valid", value_valid, 0);
    drive(c_s0, c_tens, 4);
    drive(c_blank, c_idle, 4);
    check("late_tens_val", value, 3);
    check("late_tens_valid", value_valid, 1);
    check("late_tens_upd", n_upd - upd0, 1);

    check("no_overlap", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
